// File: rtl/dog_pkg.sv
// dog_pkg: shared DoG sample widths and keypoint field layout
package dog_pkg;
  localparam int DOG_W = 9;
  localparam int DOG_BIAS = 128;
  localparam int KP_W = 24;
  localparam int COORD_W = 11;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 11;
  localparam int POL_BIT = 22;
  function automatic logic [KP_W-1:0] kp_pack(input logic pol, input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
    kp_pack = '0;
    kp_pack[POL_BIT] = pol;
    kp_pack[Y_LSB +: COORD_W] = y;
    kp_pack[X_LSB +: COORD_W] = x;
  endfunction
endpackage

// File: rtl/dog_extrema_detector_if.sv
// dog_extrema_detector_if: keypoint FIFO read port and status toward the SPI return path
interface dog_extrema_detector_if;
  import dog_pkg::*;
  logic rd_en;
  logic [KP_W-1:0] kp_data;
  logic kp_empty;
  logic kp_full;
  logic kp_valid;
  logic [7:0] drop_cnt;
  modport master(input rd_en, output kp_data, kp_empty, kp_full, kp_valid, drop_cnt);
  modport slave(output rd_en, input kp_data, kp_empty, kp_full, kp_valid, drop_cnt);
endinterface

// File: rtl/dog_line_buffer.sv
// dog_line_buffer: two-row line store, both rows read combinationally, rows shift on write
module dog_line_buffer #(
  parameter int W = 27,
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  row1,
  output logic [W-1:0]  row2
);
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] mem2 [DEPTH];
  assign row1 = mem1[addr];
  assign row2 = mem2[addr];
  always_ff @(posedge clk)
    if (we) begin
      mem2[addr] <= mem1[addr];
      mem1[addr] <= wdata;
    end
endmodule

// File: rtl/dog_extrema_detector.sv
// dog_extrema_detector: 3x3x3 DoG extrema detection feeding a keypoint FIFO
module dog_extrema_detector
  import dog_pkg::*;
#(
  parameter int ImageW = 640,
  parameter int ImageH = 480,
  parameter int DogW = DOG_W,
  parameter int ContrastTh = 6,
  parameter int FifoDepth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_rst_n,
  input  logic                en,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  input  logic [3*DogW-1:0]   dog_i,
  dog_extrema_detector_if.master kp
);
  localparam int AW = $clog2(ImageW);
  localparam int PW = $clog2(FifoDepth);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(ImageW);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(ImageH);
  localparam logic signed [DogW:0] BIAS = (DogW+1)'(DOG_BIAS);
  localparam logic signed [DogW:0] TH = (DogW+1)'(ContrastTh);
  typedef logic [2:0][2:0][DogW-1:0] col_t;
  logic [3*DogW-1:0] lb1, lb2;
  col_t [1:0] win;
  col_t col_new;
  logic [1:0] fill;
  logic [DogW-1:0] v [27];
  logic [26:0] gt, lt;
  logic signed [DogW:0] diff;
  logic eval, is_max, is_min, kp_v;
  logic [KP_W-1:0] kp_e;
  dog_line_buffer #(.W(3*DogW), .DEPTH(ImageW)) u_lb (
    .clk(clk), .we(en), .addr(pix_x[AW-1:0]), .wdata(dog_i), .row1(lb1), .row2(lb2)
  );
  // incoming column, row 0 is the oldest line (y-2)
  always_comb
    for (int s = 0; s < 3; s++) begin
      col_new[s][0] = lb2[s*DogW +: DogW];
      col_new[s][1] = lb1[s*DogW +: DogW];
      col_new[s][2] = dog_i[s*DogW +: DogW];
    end
  // cube index = col*9 + scale*3 + row; the centre (col x-1, scale1, row y-1) is 13
  for (genvar i = 0; i < 27; i++) begin : g_cmp
    if (i / 9 == 2) begin : g_new
      assign v[i] = col_new[(i/3)%3][i%3];
    end else begin : g_win
      assign v[i] = win[i/9][(i/3)%3][i%3];
    end
    assign gt[i] = i == 13 ? 1'b1 : v[13] > v[i];
    assign lt[i] = i == 13 ? 1'b1 : v[13] < v[i];
  end
  assign diff = $signed({1'b0, v[13]}) - BIAS;
  assign is_max = &gt && diff > TH;
  assign is_min = &lt && diff < -TH;
  assign eval = en && fill == 2'd2 && pix_x >= 11'd2 && pix_y >= 11'd2 && pix_x < X_LIM && pix_y < Y_LIM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win <= '0;
      fill <= '0;
      kp_v <= 1'b0;
      kp_e <= '0;
    end else if (!frame_rst_n) begin
      fill <= '0;
      kp_v <= 1'b0;
    end else begin
      kp_v <= eval && (is_max || is_min);
      if (en) begin
        kp_e <= kp_pack(is_max, pix_y - 1'b1, pix_x - 1'b1);
        win <= {col_new, win[1]};
        fill <= pix_x == '0 ? 2'd1 : fill == 2'd2 ? 2'd2 : fill + 2'd1;
      end
    end
  logic [KP_W-1:0] mem [FifoDepth];
  logic [PW-1:0] wp, rp, rp_n;
  logic [PW:0] cnt, cnt_n;
  logic [KP_W-1:0] head_q, head_n;
  logic [7:0] drop;
  logic push, pop;
  assign kp.kp_empty = cnt == '0;
  assign kp.kp_full = cnt == (PW+1)'(FifoDepth);
  assign kp.kp_valid = kp_v;
  assign kp.kp_data = head_q;
  assign kp.drop_cnt = drop;
  assign pop = kp.rd_en && !kp.kp_empty;
  assign push = kp_v && (!kp.kp_full || pop);
  assign rp_n = rp + PW'(pop);
  assign cnt_n = cnt + (PW+1)'(push) - (PW+1)'(pop);
  // a push landing on the new head slot bypasses the array
  assign head_n = cnt_n == '0 ? '0 : push && wp == rp_n ? kp_e : mem[rp_n];
  always_ff @(posedge clk)
    if (push) mem[wp] <= kp_e;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      head_q <= '0;
      drop <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp_n;
      cnt <= cnt_n;
      head_q <= head_n;
      if (kp_v && !push && drop != 8'hff) drop <= drop + 8'd1;
    end
endmodule

// File: tb/tb_dog_extrema_detector.sv
// tb_dog_extrema_detector: frame-level reference model vs streamed DUT keypoints
module tb_dog_extrema_detector;
  localparam int W = 640, H = 480;
  logic clk = 0, rst_n = 1, frame_rst_n = 1, en = 0;
  logic [10:0] pix_x = 0, pix_y = 0;
  logic [26:0] dog_i = 0;
  dog_extrema_detector_if kp();
  dog_extrema_detector u_dut (
    .clk(clk), .rst_n(rst_n), .frame_rst_n(frame_rst_n), .en(en),
    .pix_x(pix_x), .pix_y(pix_y), .dog_i(dog_i), .kp(kp)
  );
  always #5 clk = ~clk;
  logic [26:0] fr [H][W];
  logic [23:0] exp_q[$];
  logic [23:0] found[$];
  int checks = 0, failures = 0, exp_drop = 0, vcount = 0, cyc = 0;
  bit pov = 0;
  always @(negedge clk) if (kp.kp_valid) vcount++;
  always @(posedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL timeout cycles=%0d limit=60000", cyc);
      $fatal(1);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int smp(input int x, input int y, input int s);
    return int'(fr[y][x][s*9 +: 9]);
  endfunction
  task automatic fill_frame(input int ws, input int hs, input logic [8:0] val);
    for (int y = 0; y < hs; y++) for (int x = 0; x < ws; x++) fr[y][x] = {val, val, val};
  endtask
  task automatic poke(input int x, input int y, input int s, input logic [8:0] val);
    fr[y][x][s*9 +: 9] = val;
  endtask
  // every interior pixel of the streamed region, judged against its 26 neighbours
  task automatic model(input int ws, input int hs);
    found.delete();
    for (int cy = 1; cy <= hs - 2; cy++)
      for (int cx = 1; cx <= ws - 2; cx++) begin
        int c;
        bit mx, mn;
        c = smp(cx, cy, 1);
        mx = 1;
        mn = 1;
        for (int s = 0; s < 3; s++)
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (s != 1 || dy != 0 || dx != 0) begin
                int n;
                n = smp(cx + dx, cy + dy, s);
                if (c <= n) mx = 0;
                if (c >= n) mn = 0;
              end
        if ((mx && c - 128 > 6) || (mn && 128 - c > 6))
          found.push_back({1'b0, mx, 11'(cy), 11'(cx)});
      end
  endtask
  task automatic tick();
    @(negedge clk);
    kp.rd_en = pov && kp.kp_valid;
    if (kp.rd_en) begin
      if (exp_q.size() > 0) check("pop_push_head", kp.kp_data, exp_q.pop_front());
      else check("pop_on_empty_ignored", kp.kp_empty, 1);
    end
  endtask
  task automatic stream(input int ws, input int hs, input int extra, input int gap);
    for (int i = 0; i < ws * hs + extra; i++) begin
      tick();
      en = 1;
      pix_x = 11'(i % ws);
      pix_y = 11'(i / ws);
      dog_i = fr[i / ws][i % ws];
      if (gap > 0) repeat ($urandom_range(0, gap)) begin
        tick();
        en = 0;
      end
    end
    tick();
    en = 0;
    repeat (4) tick();
  endtask
  task automatic run_frame(input string tag, input int ws, input int hs, input int gap);
    int v0;
    v0 = vcount;
    model(ws, hs);
    stream(ws, hs, 0, gap);
    check({tag, "_pulses"}, vcount - v0, found.size());
    foreach (found[i])
      if (exp_q.size() < 16) exp_q.push_back(found[i]);
      else if (exp_drop < 255) exp_drop++;
  endtask
  task automatic drain(input string tag);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (kp.kp_empty) break;
      if (exp_q.size() > 0) check({tag, "_data"}, kp.kp_data, exp_q.pop_front());
      else check({tag, "_extra"}, kp.kp_data, 0);
      kp.rd_en = 1;
    end
    tick();
    check({tag, "_empty"}, kp.kp_empty, 1);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_data0"}, kp.kp_data, 0);
    check({tag, "_drop"}, kp.drop_cnt, exp_drop);
  endtask
  task automatic peaks17();
    int k;
    k = 0;
    fill_frame(20, 12, 128);
    for (int y = 2; y <= 8; y += 3)
      for (int x = 2; x <= 17; x += 3)
        if (k < 17) begin
          poke(x, y, 1, 140);
          k++;
        end
  endtask
  initial begin
    kp.rd_en = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", kp.kp_valid, 0);
    check("rst_empty", kp.kp_empty, 1);
    check("rst_full", kp.kp_full, 0);
    check("rst_data", kp.kp_data, 0);
    check("rst_drop", kp.drop_cnt, 0);
    rst_n = 1;
    fill_frame(16, 14, 128);
    poke(10, 10, 1, 140);
    run_frame("max", 16, 14, 3);
    check("max_head", kp.kp_data, {1'b0, 1'b1, 11'd10, 11'd10});
    drain("max");
    poke(11, 10, 0, 140);
    run_frame("tie", 16, 14, 1);
    check("tie_empty", kp.kp_empty, 1);
    drain("tie");
    fill_frame(16, 14, 128);
    poke(10, 10, 1, 133);
    run_frame("lowc", 16, 14, 0);
    check("lowc_empty", kp.kp_empty, 1);
    poke(10, 10, 1, 120);
    run_frame("min", 16, 14, 2);
    check("min_head", kp.kp_data, {1'b0, 1'b0, 11'd10, 11'd10});
    drain("min");
    fill_frame(640, 8, 128);
    poke(0, 5, 1, 140);
    poke(639, 5, 1, 140);
    run_frame("bordx", 640, 8, 0);
    check("bordx_empty", kp.kp_empty, 1);
    fill_frame(8, 480, 128);
    poke(5, 479, 1, 140);
    run_frame("bordy", 8, 480, 0);
    check("bordy_empty", kp.kp_empty, 1);
    drain("border");
    peaks17();
    run_frame("p17", 20, 12, 1);
    check("p17_full", kp.kp_full, 1);
    check("p17_drop", kp.drop_cnt, 1);
    pov = 1;
    fill_frame(8, 5, 128);
    poke(3, 2, 1, 140);
    run_frame("poppush", 8, 5, 0);
    pov = 0;
    check("poppush_full", kp.kp_full, 1);
    check("poppush_drop", kp.drop_cnt, 1);
    drain("p17");
    pov = 1;
    run_frame("emptypop", 8, 5, 0);
    pov = 0;
    check("emptypop_stored", kp.kp_empty, 0);
    drain("emptypop");
    begin
      int v0;
      fill_frame(8, 101, 128);
      poke(3, 99, 1, 140);
      v0 = vcount;
      model(8, 100);
      stream(8, 100, 2, 0);
      check("oldframe_pulses", vcount - v0, found.size());
      tick();
      frame_rst_n = 0;
      tick();
      frame_rst_n = 1;
    end
    fill_frame(8, 6, 128);
    poke(3, 0, 1, 140);
    poke(3, 3, 1, 140);
    run_frame("newframe", 8, 6, 2);
    check("newframe_head", kp.kp_data, {1'b0, 1'b1, 11'd3, 11'd3});
    drain("newframe");
    for (int f = 0; f < 5; f++) begin
      int ws, hs;
      ws = $urandom_range(6, 20);
      hs = $urandom_range(5, 12);
      for (int y = 0; y < hs; y++)
        for (int x = 0; x < ws; x++) begin
          fr[y][x] = {9'($urandom_range(124, 132)), 9'($urandom_range(124, 132)), 9'($urandom_range(124, 132))};
          if ($urandom_range(0, 9) == 0) poke(x, y, $urandom_range(0, 2), 9'($urandom_range(100, 160)));
        end
      run_frame("rand", ws, hs, 2);
      drain("rand");
    end
    peaks17();
    run_frame("prereset", 20, 12, 0);
    check("prereset_drop", kp.drop_cnt, exp_drop);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_empty", kp.kp_empty, 1);
    check("arst_full", kp.kp_full, 0);
    check("arst_data", kp.kp_data, 0);
    check("arst_drop", kp.drop_cnt, 0);
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1;
    fill_frame(16, 14, 128);
    poke(10, 10, 1, 140);
    run_frame("postrst", 16, 14, 1);
    drain("postrst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
